// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - Sequential restoring divider (divu/divs/remu) with flush.
// Optional DIV_BYPASS_EN: a zero divisor skips CALC/FIX and completes directly.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [4:0] OP_DIVU = 5'b01101;
    localparam logic [4:0] OP_DIVS = 5'b01110;
    localparam logic [4:0] OP_REMU = 5'b01111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] div_q;
    logic [XLEN-1:0] res_q;
    logic            is_rem_q;
    logic            neg_q;

    logic            op_ok;
    logic            is_divs;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] rem_nxt;
    logic            div_zero;

    always_comb begin
        op_ok    = (alu_op_i == OP_DIVU) || (alu_op_i == OP_DIVS) || (alu_op_i == OP_REMU);
        is_divs  = (alu_op_i == OP_DIVS);
        a_neg    = is_divs && a_i[XLEN-1];
        b_neg    = is_divs && b_i[XLEN-1];
        a_abs    = a_neg ? -a_i : a_i;
        b_abs    = b_neg ? -b_i : b_i;
        // Partial remainder stays below the divisor, so the low XLEN bits of the
        // difference are exact whenever the subtraction is taken.
        shifted  = {rem_q, quo_q[XLEN-1]};
        ge       = (shifted >= {1'b0, div_q});
        rem_nxt  = ge ? (shifted[XLEN-1:0] - div_q) : shifted[XLEN-1:0];
        div_zero = (div_q == '0);
    end

    assign busy_o = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            res_q    <= '0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i && !flush_i && op_ok) begin
                        quo_q    <= a_abs;
                        div_q    <= b_abs;
                        rem_q    <= '0;
                        cnt      <= '0;
                        is_rem_q <= (alu_op_i == OP_REMU);
                        neg_q    <= a_neg ^ b_neg;
`ifdef DIV_BYPASS_EN
                        if (b_i == '0) begin
                            res_q <= (alu_op_i == OP_REMU) ? a_i : '1;
                            state <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
`else
                        state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[XLEN-2:0], ge};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    // A zero divisor already yields all ones; sign fix-up is skipped.
                    if (is_rem_q)
                        res_q <= rem_q;
                    else if (neg_q && !div_zero)
                        res_q <= -quo_q;
                    else
                        res_q <= quo_q;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done_o   <= 1'b1;
                    result_o <= res_q;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (flush_i)
                state <= S_IDLE;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - Directed and random checks of muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;
`ifdef DIV_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [4:0] DIVU = 5'b01101;
    localparam logic [4:0] DIVS = 5'b01110;
    localparam logic [4:0] REMU = 5'b01111;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [4:0]      alu_op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_res;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .alu_op_i (alu_op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub, q;
        if (op == DIVU) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        if (op == REMU) return (b == 0) ? a : a % b;
        if (b == 0) return 32'hFFFF_FFFF;
        ua = a[31] ? (64'h1_0000_0000 - 64'(a)) : 64'(a);
        ub = b[31] ? (64'h1_0000_0000 - 64'(b)) : 64'(b);
        q  = ua / ub;
        return (a[31] ^ b[31]) ? 32'(-q) : 32'(q);
    endfunction

    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int flush_at);
        int cycles = 0;
        int busy_cnt = 0;
        int exp_lat;
        logic [31:0] exp;
        exp     = model(op, a, b);
        exp_lat = (BYP && b == 0) ? 1 : XLEN + 2;
        alu_op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        step();
        start_i = 1'b0;
        while (!done_o && cycles < 100) begin
            if (busy_o) busy_cnt++;
            flush_i = (cycles == flush_at);
            step();
            cycles++;
        end
        flush_i = 1'b0;
        chk({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        chk({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
        step();
        chk({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
        chk({tag, "_result_hold"}, result_o, exp);
        last_res = exp;
    endtask

    initial begin
        int pulses;
        int done_at;
        logic [31:0] res_seen;
        logic [4:0] rop;
        logic [31:0] ra, rb;

        rst = 1'b1; start_i = 1'b0; alu_op_i = '0; a_i = '0; b_i = '0; flush_i = 1'b0;
        last_res = '0;
        step(); step();
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_result", result_o, 32'd0);
        rst = 1'b0;
        step();

        do_op("divu_100_7", DIVU, 32'd100, 32'd7, -1);
        do_op("remu_100_7", REMU, 32'd100, 32'd7, -1);
        do_op("divs_m100_7", DIVS, 32'hFFFF_FF9C, 32'd7, -1);
        do_op("divs_ovf", DIVS, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_op("divu_5_0", DIVU, 32'd5, 32'd0, -1);
        do_op("divs_m5_0", DIVS, 32'hFFFF_FFFB, 32'd0, -1);
        do_op("remu_5_0", REMU, 32'd5, 32'd0, -1);
        do_op("divs_7_m2", DIVS, 32'd7, 32'hFFFF_FFFE, -1);
        do_op("flush_in_done", DIVU, 32'd1000, 32'd10, XLEN + 1);

        // Flush on cycle 10 of an operation
        alu_op_i = DIVU; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (9) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_no_done", 32'(done_o), 32'd0);
        chk("flush_result_kept", result_o, last_res);
        do_op("after_flush", DIVU, 32'd100, 32'd7, -1);

        // Second start while busy is ignored
        alu_op_i = DIVU; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        step();
        start_i = 1'b0;
        pulses = 0; done_at = -1; res_seen = '0;
        for (int c = 1; c <= 50; c++) begin
            start_i = (c == 5);
            if (c == 5) begin a_i = 32'd9; b_i = 32'd3; end
            step();
            if (done_o) begin pulses++; done_at = c; res_seen = result_o; end
        end
        start_i = 1'b0;
        chk("busy_start_pulses", 32'(pulses), 32'd1);
        chk("busy_start_latency", 32'(done_at), 32'(XLEN + 2));
        chk("busy_start_result", res_seen, 32'd14);
        last_res = 32'd14;

        // Flush and start together
        alu_op_i = DIVU; a_i = 32'd50; b_i = 32'd5; start_i = 1'b1; flush_i = 1'b1;
        step();
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush_start_busy", 32'(busy_o), 32'd0);

        // Asynchronous reset in the middle of CALC
        alu_op_i = DIVU; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (20) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_result", result_o, 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        #2 rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done_o) pulses++;
        end
        chk("arst_no_done", 32'(pulses), 32'd0);
        last_res = '0;

        // Unsupported op code
        alu_op_i = 5'b00010; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("unsup_busy", 32'(busy_o), 32'd0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            if (busy_o) pulses++;
            step();
            if (done_o) pulses++;
        end
        chk("unsup_quiet", 32'(pulses), 32'd0);
        chk("unsup_result", result_o, 32'd0);

        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0: rop = DIVU;
                1: rop = DIVS;
                default: rop = REMU;
            endcase
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                default: rb = $urandom;
            endcase
            do_op($sformatf("rand%0d", i), rop, ra, rb, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; iteration count equals XLEN.
REQ-002 clk  input  1  Single clock; all state updates on rising edge.
REQ-003 rst  input  1  One clock; reset is asynchronous and active-high.
REQ-004 start_i  input  1  Request to begin an operation; sampled only in IDLE.
REQ-005 alu_op_i  input  5  Decoder op code: divu 01101, divs 01110, remu 01111; all other codes unsupported.
REQ-006 a_i  input  XLEN  Dividend; sampled with start_i.
REQ-007 b_i  input  XLEN  Divisor; sampled with start_i.
REQ-008 flush_i  input  1  Abort the current operation.
REQ-009 busy_o  output  1  High whenever state is not IDLE; drives pipeline stall.
REQ-010 done_o  output  1  One-cycle pulse; result_o is valid in that cycle.
REQ-011 result_o  output  XLEN  Quotient or remainder; holds its value between done_o pulses.

Function
REQ-012 States: IDLE, CALC, FIX, DONE; 2-bit encoded; the next-state function is total.
REQ-013 IDLE->CALC when start_i=1, flush_i=0, and alu_op_i is supported; operands and op are latched on that edge.
- For divs: latch absolute values and record quotient sign = a_sign XOR b_sign.
REQ-014 start_i with an unsupported op code is ignored: state stays IDLE and no done_o is produced.
REQ-015 start_i while busy_o=1 is ignored; the latched operands are unchanged.
REQ-016 CALC runs a restoring radix-2 unsigned divide for exactly XLEN cycles.
- Iteration counter 0..XLEN-1; at XLEN-1 go to FIX.
REQ-017 FIX (1 cycle): select quotient or remainder; for divs, negate the quotient when the recorded sign is 1; go to DONE.
REQ-018 DONE (1 cycle): done_o=1 and result_o updated; next state IDLE.
REQ-019 Latency: start accepted at edge N -> done_o high in the cycle after edge N+XLEN+2 (34 cycles for XLEN=32); a new start is accepted in the cycle after DONE.
REQ-020 Divisor zero:
- divu and divs return all ones.
- remu returns a_i.
- divs does not apply sign correction when the divisor is zero.
REQ-021 divs overflow: 0x80000000 / 0xFFFFFFFF returns 0x80000000 with no special-case logic beyond REQ-017.
REQ-022 flush_i=1 in any state -> IDLE on the next edge.
- done_o is not asserted for the flushed operation.
- result_o keeps its prior value.
REQ-023 flush_i and start_i in the same cycle: flush wins; no operation starts.
REQ-024 A flush in the DONE cycle does not suppress that cycle's done_o pulse.

Reset
REQ-025 Asynchronous assertion of rst forces state IDLE, busy_o=0, done_o=0, result_o=0, iteration counter=0, and all latched operands to 0.
REQ-026 Reset deassertion mid-operation is not special-cased: the block restarts from IDLE and the aborted operation produces no done_o.

Configuration
REQ-027 Macro DIV_BYPASS_EN defined: a divisor of zero goes IDLE->DONE directly, with done_o one cycle after the start edge and the REQ-020 values.
REQ-028 Macro DIV_BYPASS_EN undefined: a divisor of zero takes the full CALC/FIX path with the REQ-019 latency and the same REQ-020 values, with no bypass logic present.

Verification
REQ-029 divu a=100 b=7 -> done_o 34 cycles after the start edge, result_o=14, busy_o high for 34 cycles.
REQ-030 remu a=100 b=7 -> result_o=2; divs a=0xFFFFFF9C (-100) b=7 -> result_o=0xFFFFFFF2 (-14).
REQ-031 divs a=0x80000000 b=0xFFFFFFFF -> result_o=0x80000000.
- Then divu a=5 b=0 -> 0xFFFFFFFF, at latency 1 with DIV_BYPASS_EN and 34 without.
REQ-032 divu 100/7 with flush_i pulsed on cycle 10 -> busy_o=0 on the next cycle, no done_o, result_o unchanged.
- A new start on the following cycle completes normally.
REQ-033 Second start_i (divu 9/3) issued on cycle 5 of an active divu 100/7 -> ignored; a single done_o with result_o=14.
REQ-034 rst asserted asynchronously on cycle 20 of CALC -> busy_o=0 and result_o=0 immediately; no done_o.
- An unsupported op code (00010) with start_i -> busy_o stays 0.
